// File: rtl/bitdelay_line.sv
// Multi-channel delay line clocked by prescaler ticks, with a run-time tap select,
// a fill/valid tracker and edge detection on the delayed output.
module bitdelay_line #(
   parameter int   WIDTH     = 1,
   parameter int   DEPTH     = 4,
   parameter int   DLYW      = 3,
   parameter logic RESET_VAL = 1'b0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             Prescale_EN,
   input  logic             clear,
   input  logic [DLYW-1:0]  delay_sel,
   input  logic [WIDTH-1:0] rx,
   output logic [WIDTH-1:0] puffer,
   output logic [WIDTH-1:0] edge_rise,
   output logic [WIDTH-1:0] edge_fall,
   output logic             valid
);

   localparam logic [WIDTH-1:0] RESET_VEC = {WIDTH{RESET_VAL}};
   localparam logic [DLYW-1:0]  DEPTH_SEL = DLYW'(DEPTH);

   logic [WIDTH-1:0] stage [1:DEPTH];
   logic [WIDTH-1:0] prev;
   logic [DLYW-1:0]  d_eff;
   logic [DLYW-1:0]  dsel_q;
   logic             dsel_primed;
   logic [DLYW-1:0]  fill;
   logic             sel_change;

   always_comb begin
      if (delay_sel == '0)
         d_eff = DLYW'(1);
      else if (delay_sel > DEPTH_SEL)
         d_eff = DEPTH_SEL;
      else
         d_eff = delay_sel;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int k = 1; k <= DEPTH; k++)
            stage[k] <= RESET_VEC;
      end else if (clear) begin
         for (int k = 1; k <= DEPTH; k++)
            stage[k] <= RESET_VEC;
      end else if (Prescale_EN) begin
         stage[1] <= rx;
         for (int k = 2; k <= DEPTH; k++)
            stage[k] <= stage[k-1];
      end
   end

   // Output tap follows delay_sel directly so a delay change takes effect at once.
   always_comb begin
      puffer = stage[1];
      for (int k = 2; k <= DEPTH; k++)
         if (d_eff == DLYW'(k))
            puffer = stage[k];
   end

   // The first clock after reset only captures delay_sel; it never counts as a change.
   assign sel_change = dsel_primed && (delay_sel != dsel_q);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         dsel_q      <= '0;
         dsel_primed <= 1'b0;
         fill        <= '0;
         prev        <= RESET_VEC;
      end else begin
         dsel_q      <= delay_sel;
         dsel_primed <= 1'b1;
         if (clear || sel_change)
            fill <= '0;
         else if (Prescale_EN && (fill < d_eff))
            fill <= fill + DLYW'(1);
         prev <= clear ? RESET_VEC : puffer;
      end
   end

   assign valid     = (fill >= d_eff);
   assign edge_rise = puffer & ~prev & {WIDTH{valid}};
   assign edge_fall = ~puffer & prev & {WIDTH{valid}};

endmodule

// File: tb/tb_bitdelay_line.sv
// Bench for bitdelay_line: a queue-based model checked every cycle plus
// hand-computed expectations for the directed scenarios.
module tb_bitdelay_line;

   localparam int   WIDTH = 1;
   localparam int   DEPTH = 4;
   localparam int   DLYW  = 3;
   localparam logic RV    = 1'b0;

   logic            clock = 1'b0;
   logic            reset;
   logic            Prescale_EN;
   logic            clear;
   logic [DLYW-1:0] delay_sel;
   logic            rx;
   logic            puffer, edge_rise, edge_fall, valid;

   int checks   = 0;
   int failures = 0;

   bitdelay_line #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DLYW(DLYW), .RESET_VAL(RV)) dut (
      .clock(clock), .reset(reset), .Prescale_EN(Prescale_EN), .clear(clear),
      .delay_sel(delay_sel), .rx(rx), .puffer(puffer), .edge_rise(edge_rise),
      .edge_fall(edge_fall), .valid(valid)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s t=%0t actual=%0b required=%0b", name, $time, act, exp);
      end
   endtask

   function automatic int deff(input int s);
      if (s == 0) return 1;
      if (s > DEPTH) return DEPTH;
      return s;
   endfunction

   // Model: newest tick sample at the front of a queue, a plain tick count since
   // the last reset/clear/delay change, and the output seen at the previous clock.
   logic m_hist[$];
   int   m_ticks;
   logic m_prev;
   logic [DLYW-1:0] m_dsel;
   logic m_primed;
   logic m_cur;
   logic m_chg;

   task automatic model_reset();
      m_hist = {};
      for (int i = 0; i < DEPTH; i++) m_hist.push_back(RV);
      m_ticks  = 0;
      m_prev   = RV;
      m_dsel   = '0;
      m_primed = 1'b0;
   endtask

   initial model_reset();

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         model_reset();
      end else begin
         m_cur = m_hist[deff(int'(delay_sel)) - 1];
         m_chg = m_primed && (delay_sel != m_dsel);
         if (clear) begin
            for (int i = 0; i < DEPTH; i++) m_hist[i] = RV;
            m_ticks = 0;
            m_prev  = RV;
         end else begin
            if (Prescale_EN) begin
               m_hist.push_front(rx);
               void'(m_hist.pop_back());
            end
            if (m_chg) m_ticks = 0;
            else if (Prescale_EN && m_ticks < 1000) m_ticks++;
            m_prev = m_cur;
         end
         m_dsel   = delay_sel;
         m_primed = 1'b1;
      end
   end

   always @(negedge clock) begin
      int   d;
      logic p, v;
      d = deff(int'(delay_sel));
      p = m_hist[d - 1];
      v = (m_ticks >= d);
      check("cyc_puffer", puffer, p);
      check("cyc_valid", valid, v);
      check("cyc_edge_rise", edge_rise, p & ~m_prev & v);
      check("cyc_edge_fall", edge_fall, ~p & m_prev & v);
   end

   task automatic cyc(input logic en, input logic r);
      Prescale_EN = en;
      rx          = r;
      @(posedge clock);
      #1;
      Prescale_EN = 1'b0;
   endtask

   task automatic tick(input logic r);
      cyc(1'b1, r);
      $display("tick sel=%0d rx=%0b puffer=%0b valid=%0b rise=%0b fall=%0b",
               delay_sel, r, puffer, valid, edge_rise, edge_fall);
   endtask

   task automatic idle(input int n);
      repeat (n) cyc(1'b0, rx);
   endtask

   initial begin
      reset = 1'b1; Prescale_EN = 1'b0; clear = 1'b0; delay_sel = 3'd1; rx = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      check("rst_puffer", puffer, 1'b0);
      check("rst_valid", valid, 1'b0);
      check("rst_rise", edge_rise, 1'b0);
      check("rst_fall", edge_fall, 1'b0);
      reset = 1'b0;

      // basic delay of one tick
      rx = 1'b1; idle(3);
      tick(1'b1);
      check("d1_puffer", puffer, 1'b1);
      check("d1_valid", valid, 1'b1);
      check("d1_rise", edge_rise, 1'b1);
      cyc(1'b0, 1'b1);
      check("d1_rise_once", edge_rise, 1'b0);
      idle(2);

      // deep delay of four ticks
      clear = 1'b1; cyc(1'b0, 1'b0); clear = 1'b0;
      check("clr_puffer", puffer, 1'b0);
      delay_sel = 3'd4; cyc(1'b0, 1'b0);
      tick(1'b1); idle(3); tick(1'b0); idle(3); tick(1'b1);
      check("d4_valid_early", valid, 1'b0);
      idle(3); tick(1'b1);
      check("d4_puffer1", puffer, 1'b1);
      check("d4_valid", valid, 1'b1);
      check("d4_rise", edge_rise, 1'b1);
      idle(3); tick(1'b0);
      check("d4_puffer2", puffer, 1'b0);
      check("d4_fall", edge_fall, 1'b1);
      idle(3); tick(1'b0);
      check("d4_puffer3", puffer, 1'b1);
      idle(3); tick(1'b0);
      check("d4_puffer4", puffer, 1'b1);
      check("d4_no_rise", edge_rise, 1'b0);
      idle(3);

      // clamping: 0 acts as 1, 7 acts as DEPTH
      delay_sel = 3'd0; cyc(1'b0, 1'b0);
      tick(1'b1);
      check("c0_puffer", puffer, 1'b1);
      check("c0_valid", valid, 1'b1);
      idle(1); tick(1'b0);
      check("c0_puffer2", puffer, 1'b0);
      check("c0_fall", edge_fall, 1'b1);
      delay_sel = 3'd7; cyc(1'b0, 1'b0);
      tick(1'b1); tick(1'b0); tick(1'b0);
      check("c7_valid_early", valid, 1'b0);
      tick(1'b0);
      check("c7_valid", valid, 1'b1);
      check("c7_puffer", puffer, 1'b1);
      idle(2);

      // mid-stream change from 3 to 1
      delay_sel = 3'd3; cyc(1'b0, 1'b0);
      tick(1'b1); tick(1'b0); tick(1'b0);
      check("m3_valid", valid, 1'b1);
      tick(1'b1);
      check("m3_puffer", puffer, 1'b0);
      idle(2);
      @(negedge clock); #1;
      delay_sel = 3'd1; #1;
      check("m1_puffer_now", puffer, 1'b1);
      @(posedge clock); #1;
      check("m1_valid_drop", valid, 1'b0);
      check("m1_rise_masked", edge_rise, 1'b0);
      idle(1);
      check("m1_valid_still", valid, 1'b0);
      tick(1'b0);
      check("m1_valid_back", valid, 1'b1);
      check("m1_fall", edge_fall, 1'b1);

      // tick and delay change in the same clock: shift happens, fill forced to 0
      delay_sel = 3'd0; tick(1'b1);
      check("tc_puffer", puffer, 1'b1);
      check("tc_valid", valid, 1'b0);
      check("tc_rise", edge_rise, 1'b0);
      idle(1);

      // clear coincident with a tick
      delay_sel = 3'd4; cyc(1'b0, 1'b1);
      tick(1'b1); tick(1'b1); tick(1'b1); tick(1'b1);
      check("cl_pre_puffer", puffer, 1'b1);
      check("cl_pre_valid", valid, 1'b1);
      clear = 1'b1; cyc(1'b1, 1'b1); clear = 1'b0;
      check("cl_puffer", puffer, 1'b0);
      check("cl_valid", valid, 1'b0);
      check("cl_rise", edge_rise, 1'b0);
      check("cl_fall", edge_fall, 1'b0);
      for (int k = 1; k <= DEPTH; k++) begin
         delay_sel = DLYW'(k); #1;
         check("cl_stage", puffer, 1'b0);
      end
      delay_sel = 3'd4; cyc(1'b0, 1'b0);

      // async reset while fill is 2
      tick(1'b1); tick(1'b1); tick(1'b1); tick(1'b1);
      delay_sel = 3'd3; cyc(1'b0, 1'b1);
      tick(1'b1); tick(1'b1);
      check("ar_pre_puffer", puffer, 1'b1);
      check("ar_pre_valid", valid, 1'b0);
      #2; reset = 1'b1; #1;
      check("ar_puffer", puffer, 1'b0);
      check("ar_valid", valid, 1'b0);
      check("ar_rise", edge_rise, 1'b0);
      check("ar_fall", edge_fall, 1'b0);
      @(posedge clock); #1;
      delay_sel = 3'd1; reset = 1'b0;
      rx = 1'b1; idle(2);
      tick(1'b1);
      check("rc_puffer", puffer, 1'b1);
      check("rc_valid", valid, 1'b1);
      check("rc_rise", edge_rise, 1'b1);
      cyc(1'b0, 1'b1);
      check("rc_rise_once", edge_rise, 1'b0);
      idle(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
